counter_arbiter: RTL



---
 rtl/counter_arb_pkg.sv | 44 ++++
 rtl/counter_arbiter_rr_arbiter.sv | 54 +++++
 rtl/counter_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/counter_arb_pkg.sv
// Package: counter_arb_pkg
// Purpose : shared types, default sizes and the round-robin pick helper for
//           counter_arbiter and its rr_arbiter sub-module.
// Contents:
//   N_DEF, CW_DEF - default requester count and counter width
//   IW            - width of a requester index (covers up to 8 requesters)
//   state_t       - arbiter FSM states {IDLE, RUN, DONE}
//   rr_pick()     - index of first set request at or after a pointer, wrapping
package counter_arb_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 3;
  localparam int IW     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Scan n requests starting at ptr and wrapping; the first set bit wins.
  // Requests are padded to 8 bits so one function serves every legal N.
  // Returns 0 when nothing is requested; callers qualify with |req.
  function automatic logic [IW-1:0] rr_pick(input logic [7:0] req_v,
                                            input logic [IW-1:0] ptr,
                                            input int n);
    logic [IW-1:0] pick;
    logic          found;
    int            j;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      j = (int'(ptr) + k) % n;
      if ((k < n) && !found && req_v[j[2:0]]) begin
        pick  = j[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Module : rr_arbiter
// Purpose: round-robin selection for counter_arbiter. Combinational pick of
//          the first request at or after the priority pointer; the pointer
//          moves to owner+1 (mod N) whenever i_adv is strobed.
// Ports  :
//   clk, reset  - clock, asynchronous active-high reset (pointer -> 0)
//   i_req       - request vector
//   i_adv       - advance the pointer past i_owner this cycle
//   i_owner     - index of the requester that just finished / aborted
//   o_winner    - one-hot winner (all zero when no request)
//   o_idx       - winner index
//   o_any       - at least one request present
module rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  input  logic [IW-1:0] i_owner,
  output logic [N-1:0]  o_winner,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;
  logic [7:0]    w_req8;
  logic [N-1:0]  w_one;

  // Zero-extend requests to the fixed width rr_pick works on.
  always_comb begin
    w_req8         = 8'd0;
    w_req8[N-1:0]  = i_req;
  end

  assign w_one    = {{(N-1){1'b0}}, 1'b1};
  assign o_any    = |i_req;
  assign o_idx    = rr_pick(w_req8, r_ptr, N);
  assign o_winner = o_any ? (w_one << o_idx) : {N{1'b0}};

  // Priority pointer: after a run ends the finishing owner drops to lowest priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 3'd0;
    end else if (i_adv) begin
      r_ptr <= (i_owner == IW'(N-1)) ? 3'd0 : (i_owner + 3'd1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Module : counter_arbiter
// Purpose: shares one mod-2^CW step counter between N requesters. The
//          round-robin winner owns the counter for len+1 ticks, then gets a
//          one-cycle done pulse. Dropping req mid-run aborts without done.
// Ports  :
//   clk, reset  - clock, asynchronous active-high reset
//   req  [N]    - request per requester, held until done or abandonment
//   len  [N*CW] - run length per requester (requester i: bits [i*CW +: CW])
//   tick        - step strobe; the counter only advances on tick in RUN
//   gnt  [N]    - registered one-hot grant
//   busy        - high in RUN or DONE
//   num  [CW]   - live counter value
//   done [N]    - one-cycle completion pulse to the owner
//   grant_cnt [N*8] - per-requester saturating completed-run counts,
//                     present only when COUNTER_ARB_STATS_EN is defined
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] len,
  input  logic            tick,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic [CW-1:0]   num,
`ifdef COUNTER_ARB_STATS_EN
  output logic [N*8-1:0]  grant_cnt,
`endif
  output logic [N-1:0]    done
);

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [CW-1:0] r_len,   w_len_nxt;
  logic [CW-1:0] r_num,   w_num_nxt;
  logic [N-1:0]  r_gnt,   w_gnt_nxt;
  logic [N-1:0]  r_done,  w_done_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          w_adv;
  logic [N-1:0]  w_winner;
  logic [IW-1:0] w_idx;
  logic          w_any;

  rr_arbiter #(.N(N)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_req    (req),
    .i_adv    (w_adv),
    .i_owner  (r_owner),
    .o_winner (w_winner),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_len_nxt   = r_len;
    w_num_nxt   = r_num;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = {N{1'b0}};
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = RUN;
          w_owner_nxt = w_idx;
          w_len_nxt   = len[w_idx*CW +: CW];
          w_gnt_nxt   = w_winner;
          w_num_nxt   = {CW{1'b0}};
        end else begin
          w_gnt_nxt   = {N{1'b0}};
          w_num_nxt   = {CW{1'b0}};
        end
      end
      RUN: begin
        // An owner withdrawing its request wins over a same-cycle completion.
        if ((req & r_gnt) == {N{1'b0}}) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = {N{1'b0}};
          w_num_nxt   = {CW{1'b0}};
          w_adv       = 1'b1;
        end else if (tick) begin
          if (r_num == r_len) begin
            w_state_nxt = DONE;
            w_done_nxt  = r_gnt;
          end else begin
            w_num_nxt   = r_num + CW'(1);
          end
        end else begin
          w_num_nxt   = r_num;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = {N{1'b0}};
        w_num_nxt   = {CW{1'b0}};
        w_adv       = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = {N{1'b0}};
        w_num_nxt   = {CW{1'b0}};
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 3'd0;
      r_len   <= {CW{1'b0}};
      r_num   <= {CW{1'b0}};
      r_gnt   <= {N{1'b0}};
      r_done  <= {N{1'b0}};
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_len   <= w_len_nxt;
      r_num   <= w_num_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign num  = r_num;
  assign busy = r_busy;

`ifdef COUNTER_ARB_STATS_EN
  logic [N*8-1:0] r_cnt;

  // Completed-run counters; only the DONE state counts, so aborts are excluded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {(N*8){1'b0}};
    end else if (r_state == DONE) begin
      for (int i = 0; i < N; i++) begin
        if (r_gnt[i] && (r_cnt[i*8 +: 8] != 8'hFF)) begin
          r_cnt[i*8 +: 8] <= r_cnt[i*8 +: 8] + 8'd1;
        end else begin
          r_cnt[i*8 +: 8] <= r_cnt[i*8 +: 8];
        end
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign grant_cnt = r_cnt;
`endif

endmodule
